// File: rtl/if_tracker.sv
// IF-stage trace transmitter: timestamps fetch transactions on the req/gnt/rvalid bus and emits
// one completed trace element per fetched instruction with a single-cycle valid pulse.

package if_tracker_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instruction;
        logic [31:0] time_start;
        logic [31:0] time_end;
    } stage_data_t;

    typedef struct packed {
        logic        pass_through;
        stage_data_t if_data;
        stage_data_t id_data;
        stage_data_t ex_data;
        stage_data_t wb_data;
    } trace_output;

    localparam int unsigned TraceW = $bits(trace_output);

endpackage

module if_tracker
    import if_tracker_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       counter,
    input  logic              instr_req,
    input  logic              instr_gnt,
    input  logic              instr_rvalid,
    input  logic [31:0]       instr_addr,
    input  logic [31:0]       instr_rdata,
    output logic [TraceW-1:0] if_data_o,
    output logic              if_data_valid,
    output logic              overflow,
    output logic              spurious_rvalid
);

    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(MAX_OUTSTANDING);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTSTANDING - 1);

    typedef enum logic [0:0] {
        ReqIdle,
        ReqWaitGnt
    } req_state_e;

    // Request FSM
    req_state_e  state_q, state_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [31:0] pend_start_q, pend_start_d;

    logic        push_req;
    logic [31:0] push_addr;
    logic [31:0] push_start;

    // Outstanding-transaction queue
    logic [31:0]     q_addr  [MAX_OUTSTANDING];
    logic [31:0]     q_start [MAX_OUTSTANDING];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            q_empty;
    logic            q_full;
    logic            pop;
    logic            push_ok;

    // Output registers
    trace_output out_q, out_d;
    logic        valid_q, valid_d;
    logic        overflow_q, overflow_d;
    logic        spurious_q, spurious_d;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d      = state_q;
        pend_addr_d  = pend_addr_q;
        pend_start_d = pend_start_q;
        push_req     = 1'b0;
        push_addr    = '0;
        push_start   = '0;
        case (state_q)
            ReqIdle: begin
                if (instr_req) begin
                    if (instr_gnt) begin
                        push_req   = 1'b1;
                        push_addr  = instr_addr;
                        push_start = counter;
                    end else begin
                        // Timestamp is the first req cycle, not the grant cycle
                        pend_addr_d  = instr_addr;
                        pend_start_d = counter;
                        state_d      = ReqWaitGnt;
                    end
                end
            end
            ReqWaitGnt: begin
                if (instr_gnt) begin
                    push_req   = 1'b1;
                    push_addr  = pend_addr_q;
                    push_start = pend_start_q;
                    state_d    = ReqIdle;
                end else if (!instr_req) begin
                    state_d = ReqIdle;
                end
            end
            default: state_d = ReqIdle;
        endcase
    end

    always_comb begin
        q_empty  = (count_q == '0);
        q_full   = (count_q == CntFull);
        pop      = instr_rvalid && !q_empty;
        // A pop in the same cycle frees the slot the push lands in
        push_ok  = push_req && (!q_full || pop);
        count_d  = count_q + CntW'(push_ok) - CntW'(pop);
        wr_ptr_d = push_ok ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_next(rd_ptr_q) : rd_ptr_q;
    end

    always_comb begin
        out_d   = out_q;
        valid_d = 1'b0;
        if (pop) begin
            out_d                        = '0;
            out_d.if_data.addr           = q_addr[rd_ptr_q];
            out_d.if_data.instruction    = instr_rdata;
            out_d.if_data.time_start     = q_start[rd_ptr_q];
            out_d.if_data.time_end       = counter;
            valid_d                      = 1'b1;
        end
        overflow_d = overflow_q | (push_req && q_full && !pop);
        spurious_d = spurious_q | (instr_rvalid && q_empty);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ReqIdle;
            pend_addr_q  <= '0;
            pend_start_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_q        <= '0;
            valid_q      <= 1'b0;
            overflow_q   <= 1'b0;
            spurious_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_addr_q  <= pend_addr_d;
            pend_start_q <= pend_start_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_q        <= out_d;
            valid_q      <= valid_d;
            overflow_q   <= overflow_d;
            spurious_q   <= spurious_d;
        end
    end

    // Queue storage needs no reset; occupancy alone decides validity
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            q_addr[wr_ptr_q]  <= push_addr;
            q_start[wr_ptr_q] <= push_start;
        end
    end

    assign if_data_o       = out_q;
    assign if_data_valid   = valid_q;
    assign overflow        = overflow_q;
    assign spurious_rvalid = spurious_q;

endmodule
